// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB bridge arbiter slice.
package apb_arb_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ADDR = 3'd1,
    DATA = 3'd2,
    DONE = 3'd3,
    ERR  = 3'd4
  } state_t;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // The counter must be able to hold TIMEOUT itself.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   index,
  output logic            any
);

  // Walk from the farthest candidate back toward ptr+1 so the nearest set bit wins.
  always_comb begin
    int idx_s;
    index = '0;
    any   = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      idx_s = int'(ptr) + k;
      idx_s = (idx_s >= NREQ) ? (idx_s - NREQ) : idx_s;
      index = req[idx_s] ? PW'(idx_s) : index;
      any   = any | req[idx_s];
    end
    pick = any ? (NREQ'(1) << index) : '0;
  end

endmodule

// File: rtl/apb_bridge_arbiter.sv
// Round-robin arbiter sharing one AHB-to-APB bridge controller among NREQ requesters.
module apb_bridge_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic             Hclk,
  input  logic             Hreset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_write,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  done,
  output logic [NREQ-1:0]  err,
  output logic [DW-1:0]    rdata,
  output logic             br_valid,
  output logic             br_write,
  output logic [AW-1:0]    br_addr,
  output logic [DW-1:0]    br_wdata,
  input  logic             br_ready,
  input  logic [DW-1:0]    br_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = cnt_width(TIMEOUT);

  state_t          state_r, state_s;
  logic [PW-1:0]   ptr_r;
  logic [CW-1:0]   cnt_r;
  logic [NREQ-1:0] gnt_r, done_r, err_r;
  logic [DW-1:0]   rdata_r;
  logic            br_valid_r, br_write_r;
  logic [AW-1:0]   br_addr_r;
  logic [DW-1:0]   br_wdata_r;
  logic [NREQ-1:0] pick_s;
  logic [PW-1:0]   idx_s;
  logic            any_s;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req   (req),
    .ptr   (ptr_r),
    .pick  (pick_s),
    .index (idx_s),
    .any   (any_s)
  );

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (any_s) state_s = ADDR;
        else       state_s = IDLE;
      end
      ADDR: state_s = DATA;
      DATA: begin
        if (br_ready)                         state_s = DONE;
        else if (cnt_r == CW'(TIMEOUT - 1))   state_s = ERR;
        else                                  state_s = DATA;
      end
      DONE:    state_s = IDLE;
      ERR:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_r    <= IDLE;
      ptr_r      <= PW'(NREQ - 1);
      cnt_r      <= '0;
      gnt_r      <= '0;
      done_r     <= '0;
      err_r      <= '0;
      rdata_r    <= '0;
      br_valid_r <= 1'b0;
      br_write_r <= 1'b0;
      br_addr_r  <= '0;
      br_wdata_r <= '0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (any_s) begin
            gnt_r      <= pick_s;
            ptr_r      <= idx_s;
            cnt_r      <= '0;
            br_valid_r <= 1'b1;
            br_write_r <= req_write[idx_s];
            br_addr_r  <= req_addr[int'(idx_s)*AW +: AW];
            br_wdata_r <= req_wdata[int'(idx_s)*DW +: DW];
          end
        end
        ADDR: br_valid_r <= 1'b0;
        DATA: begin
          if (br_ready) begin
            done_r <= gnt_r;
            // Writes leave the last captured read data untouched.
            if (!br_write_r) rdata_r <= br_rdata;
          end else if (cnt_r == CW'(TIMEOUT - 1)) begin
            err_r <= gnt_r;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        DONE, ERR: begin
          done_r     <= '0;
          err_r      <= '0;
          gnt_r      <= '0;
          cnt_r      <= '0;
          br_write_r <= 1'b0;
          br_addr_r  <= '0;
          br_wdata_r <= '0;
        end
        default: begin
          gnt_r      <= '0;
          done_r     <= '0;
          err_r      <= '0;
          br_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = gnt_r;
  assign done     = done_r;
  assign err      = err_r;
  assign rdata    = rdata_r;
  assign br_valid = br_valid_r;
  assign br_write = br_write_r;
  assign br_addr  = br_addr_r;
  assign br_wdata = br_wdata_r;

endmodule

// File: tb/tb_apb_bridge_arbiter.sv
// Directed bench for apb_bridge_arbiter (NREQ=4, TIMEOUT=4) with hand-computed expectations.
module tb_apb_bridge_arbiter;

  logic         Hclk = 1'b0;
  logic         Hreset;
  logic [3:0]   req, req_write;
  logic [127:0] req_addr, req_wdata;
  logic [3:0]   gnt, done, err;
  logic [31:0]  rdata, br_addr, br_wdata, br_rdata;
  logic         br_valid, br_write, br_ready;

  int tests = 0;
  int fails = 0;

  apb_bridge_arbiter #(.NREQ(4), .AW(32), .DW(32), .TIMEOUT(4)) dut (
    .Hclk(Hclk), .Hreset(Hreset),
    .req(req), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .err(err), .rdata(rdata),
    .br_valid(br_valid), .br_write(br_write), .br_addr(br_addr), .br_wdata(br_wdata),
    .br_ready(br_ready), .br_rdata(br_rdata)
  );

  always #5 Hclk = ~Hclk;

  task automatic tick();
    @(posedge Hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0] exp_g;
    Hreset = 1'b1; req = 4'b0; req_write = 4'b0; req_addr = '0; req_wdata = '0;
    br_ready = 1'b0; br_rdata = 32'h0;
    tick(); tick();
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_done_err", 64'({done, err}), 64'h0);
    chk("rst_valid", 64'(br_valid), 64'h0);
    chk("rst_addr", 64'(br_addr), 64'h0);
    chk("rst_rdata", 64'(rdata), 64'h0);
    Hreset = 1'b0;

    // 1: single read from requester 0, zero wait.
    req = 4'b0001; req_addr[31:0] = 32'h0000_1000; br_ready = 1'b1; br_rdata = 32'hDEAD_BEEF;
    tick();
    chk("t1_gnt", 64'(gnt), 64'h1);
    chk("t1_valid", 64'(br_valid), 64'h1);
    chk("t1_addr", 64'(br_addr), 64'h1000);
    chk("t1_write", 64'(br_write), 64'h0);
    tick();
    chk("t1_data_valid", 64'(br_valid), 64'h0);
    chk("t1_data_done", 64'(done), 64'h0);
    tick();
    chk("t1_done", 64'(done), 64'h1);
    chk("t1_rdata", 64'(rdata), 64'hDEAD_BEEF);
    req = 4'b0;
    tick();
    chk("t1_idle_gnt", 64'(gnt), 64'h0);
    chk("t1_idle_done", 64'(done), 64'h0);

    // 2: all requesters held high after a reset -> strict rotation 0,1,2,3,0.
    Hreset = 1'b1; tick(); Hreset = 1'b0;
    req_addr = {32'h3000, 32'h2000, 32'h1100, 32'h0100};
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      exp_g = 4'b0001 << (t % 4);
      tick();
      chk("t2_gnt", 64'(gnt), 64'(exp_g));
      chk("t2_onehot", 64'($onehot0(gnt)), 64'h1);
      chk("t2_addr", 64'(br_addr), 64'(req_addr[(t % 4)*32 +: 32]));
      tick();
      chk("t2_data_gnt", 64'(gnt), 64'(exp_g));
      tick();
      chk("t2_done", 64'(done), 64'(exp_g));
      if (t == 4) req = 4'b0;
      tick();
      chk("t2_idle_gnt", 64'(gnt), 64'h0);
    end

    // 3: requester 2 write with three wait cycles; pointer at 0 -> winner 2.
    req_write = 4'b0100; req_addr[95:64] = 32'h40; req_wdata[95:64] = 32'h1234_5678;
    br_ready = 1'b0; br_rdata = 32'hAAAA_5555; req = 4'b0100;
    tick();
    chk("t3_gnt", 64'(gnt), 64'h4);
    chk("t3_valid", 64'(br_valid), 64'h1);
    chk("t3_write", 64'(br_write), 64'h1);
    chk("t3_addr", 64'(br_addr), 64'h40);
    req_wdata[95:64] = 32'hFFFF_0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t3_wdata", 64'(br_wdata), 64'h1234_5678);
      chk("t3_nodone", 64'(done), 64'h0);
    end
    tick();
    chk("t3_wdata4", 64'(br_wdata), 64'h1234_5678);
    br_ready = 1'b1;
    tick();
    chk("t3_done", 64'(done), 64'h4);
    chk("t3_rdata", 64'(rdata), 64'hDEAD_BEEF);
    req = 4'b0; req_write = 4'b0;
    tick();

    // 4: timeout on requester 1; pointer at 2 -> winner 1 is the only request.
    req_addr[63:32] = 32'h80; br_ready = 1'b0; req = 4'b0010;
    tick();
    chk("t4_gnt", 64'(gnt), 64'h2);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("t4_noerr", 64'({done, err}), 64'h0);
    end
    tick();
    chk("t4_err", 64'(err), 64'h2);
    chk("t4_nodone", 64'(done), 64'h0);
    chk("t4_err_gnt", 64'(gnt), 64'h2);
    req = 4'b0;
    tick();
    chk("t4_idle", 64'({gnt, err}), 64'h0);
    chk("t4_rdata", 64'(rdata), 64'hDEAD_BEEF);
    br_ready = 1'b1; br_rdata = 32'h0BAD_F00D; req = 4'b0001;
    tick();
    chk("t4_next_gnt", 64'(gnt), 64'h1);
    tick(); tick();
    chk("t4_next_done", 64'(done), 64'h1);
    chk("t4_next_rdata", 64'(rdata), 64'h0BAD_F00D);
    req = 4'b0;
    tick();

    // 5: reset during DATA of requester 1.
    br_ready = 1'b0; req = 4'b0010;
    tick();
    chk("t5_gnt", 64'(gnt), 64'h2);
    tick();
    Hreset = 1'b1;
    tick();
    chk("t5_rst_gnt", 64'(gnt), 64'h0);
    chk("t5_rst_done_err", 64'({done, err}), 64'h0);
    chk("t5_rst_valid", 64'(br_valid), 64'h0);
    chk("t5_rst_addr", 64'(br_addr), 64'h0);
    chk("t5_rst_rdata", 64'(rdata), 64'h0);
    Hreset = 1'b0; req = 4'b0001; br_ready = 1'b1;
    tick();
    chk("t5_after_gnt", 64'(gnt), 64'h1);
    chk("t5_after_err", 64'({done, err}), 64'h0);
    tick(); tick();
    chk("t5_after_done", 64'(done), 64'h1);
    req = 4'b0;
    tick();

    // 6: requester 3 drops req right after grant.
    req = 4'b1000;
    tick();
    chk("t6_gnt", 64'(gnt), 64'h8);
    req = 4'b0;
    tick(); tick();
    chk("t6_done", 64'(done), 64'h8);
    tick();
    chk("t6_idle", 64'({gnt, done}), 64'h0);
    tick();
    chk("t6_no_regrant", 64'(gnt), 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
